// File: rtl/rs_decoder_10_8_if.sv
// Bus bundle for the RS(10,8) decoder: request side (start, code_in) and
// result side (data_out, valid_out, busy, error flags, err_pos).
// slave modport is the decoder's view, master modport is the requester's view.
interface rs_decoder_10_8_if;
  logic        start;
  logic [79:0] code_in;
  logic [63:0] data_out;
  logic        valid_out;
  logic        busy;
  logic        err_detected;
  logic        err_corrected;
  logic        err_uncorrectable;
  logic [3:0]  err_pos;

  modport slave (
    input  start,
    input  code_in,
    output data_out,
    output valid_out,
    output busy,
    output err_detected,
    output err_corrected,
    output err_uncorrectable,
    output err_pos
  );

  modport master (
    output start,
    output code_in,
    input  data_out,
    input  valid_out,
    input  busy,
    input  err_detected,
    input  err_corrected,
    input  err_uncorrectable,
    input  err_pos
  );
endinterface

// File: rtl/rs_decoder_10_8.sv
// RS(10,8) over GF(256) (poly 0x11D, alpha=2): single-symbol error corrector.
// Latency: fixed 21 cycles from the start edge to the valid_out pulse.
// Backpressure: none; start is ignored while busy, results held until the next completion.
// Ports: clk, rst_n (async active-low), bus (slave): start/code_in in,
//        data_out/valid_out/busy/err_detected/err_corrected/err_uncorrectable/err_pos out.
module rs_decoder_10_8 (
  input  logic             clk,
  input  logic             rst_n,
  rs_decoder_10_8_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYND    = 2'd1,
    SEARCH  = 2'd2,
    CORRECT = 2'd3
  } state_e;

  // Multiply by alpha in GF(256): shift left, fold x^8 back in via 0x1D.
  function automatic logic [7:0] mul_alpha(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [79:0] code_q,  code_d;   // latched codeword
  logic [7:0]  s0_q,    s0_d;     // c(1)
  logic [7:0]  s1_q,    s1_d;     // c(alpha)
  logic [7:0]  prod_q,  prod_d;   // S0 * alpha^j during the search
  logic [3:0]  cnt_q,   cnt_d;    // step counter shared by SYND and SEARCH
  logic        found_q, found_d;  // a location matched during the search
  logic [3:0]  loc_q,   loc_d;    // first matching j

  logic [63:0] data_q,  data_d;
  logic        valid_q, valid_d;
  logic        det_q,   det_d;
  logic        cor_q,   cor_d;
  logic        unc_q,   unc_d;
  logic [3:0]  pos_q,   pos_d;

  // FSM output controls
  logic busy_o;
  logic latch_en;
  logic synd_en;
  logic search_en;
  logic commit_en;

  logic last_step;
  assign last_step = (cnt_q == 4'd9);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SYND;
      SYND:    if (last_step) state_d = SEARCH;
      SEARCH:  if (last_step) state_d = CORRECT;
      CORRECT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o    = 1'b0;
    latch_en  = 1'b0;
    synd_en   = 1'b0;
    search_en = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      IDLE:    latch_en  = bus.start;
      SYND:    begin busy_o = 1'b1; synd_en   = 1'b1; end
      SEARCH:  begin busy_o = 1'b1; search_en = 1'b1; end
      CORRECT: begin busy_o = 1'b1; commit_en = 1'b1; end
      default: busy_o = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Syndrome datapath: Horner evaluation, highest symbol first, so that after
  // c_0 has been folded in s1 holds c(alpha) and s0 holds c(1).
  // ---------------------------------------------------------------------------
  logic [3:0] sym_idx;
  logic [6:0] sym_base;
  logic [7:0] sym;
  logic [7:0] s0_nxt;
  logic [7:0] s1_nxt;

  assign sym_idx  = 4'd9 - cnt_q;
  assign sym_base = {sym_idx, 3'b000};
  assign sym      = code_q[sym_base +: 8];
  assign s0_nxt   = s0_q ^ sym;
  assign s1_nxt   = mul_alpha(s1_q) ^ sym;

  // A single error e at position j gives S0 = e and S1 = e*alpha^j, so the
  // location is the j for which S0*alpha^j equals S1.
  logic match;
  assign match = (prod_q == s1_q);

  // ---------------------------------------------------------------------------
  // Classification and correction, consumed on the CORRECT cycle
  // ---------------------------------------------------------------------------
  logic        no_err;
  logic        correctable;
  logic [63:0] data_fix;

  assign no_err      = (s0_q == 8'h00) && (s1_q == 8'h00);
  assign correctable = (s0_q != 8'h00) && (s1_q != 8'h00) && found_q;

  // Only data symbols (positions 2..9) are patched; a located parity error
  // leaves the data untouched.
  always_comb begin
    data_fix = code_q[79:16];
    if (correctable) begin
      for (int i = 0; i < 8; i++) begin
        if (loc_q == 4'(i + 2)) begin
          data_fix[8*i +: 8] = code_q[8*(i+2) +: 8] ^ s0_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    code_d  = code_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    loc_d   = loc_q;
    data_d  = data_q;
    det_d   = det_q;
    cor_d   = cor_q;
    unc_d   = unc_q;
    pos_d   = pos_q;
    valid_d = commit_en;

    if (latch_en) begin
      code_d  = bus.code_in;
      s0_d    = 8'h00;
      s1_d    = 8'h00;
      cnt_d   = 4'd0;
      found_d = 1'b0;
      loc_d   = 4'd0;
    end

    if (synd_en) begin
      s0_d  = s0_nxt;
      s1_d  = s1_nxt;
      cnt_d = last_step ? 4'd0 : cnt_q + 4'd1;
      // Seed the search product with the final S0 as it is being written.
      if (last_step) begin
        prod_d = s0_nxt;
      end
    end

    if (search_en) begin
      prod_d = mul_alpha(prod_q);
      cnt_d  = last_step ? 4'd0 : cnt_q + 4'd1;
      // Keep the first hit; the search still runs its full length so every
      // decode takes the same number of cycles.
      if (match && !found_q) begin
        found_d = 1'b1;
        loc_d   = cnt_q;
      end
    end

    if (commit_en) begin
      data_d = data_fix;
      det_d  = !no_err;
      cor_d  = correctable;
      unc_d  = !no_err && !correctable;
      pos_d  = correctable ? loc_q : 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      loc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      det_q   <= 1'b0;
      cor_q   <= 1'b0;
      unc_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      code_q  <= code_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      loc_q   <= loc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      det_q   <= det_d;
      cor_q   <= cor_d;
      unc_q   <= unc_d;
      pos_q   <= pos_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.data_out          = data_q;
  assign bus.valid_out         = valid_q;
  assign bus.busy              = busy_o;
  assign bus.err_detected      = det_q;
  assign bus.err_corrected     = cor_q;
  assign bus.err_uncorrectable = unc_q;
  assign bus.err_pos           = pos_q;

endmodule

// File: tb/tb_rs_decoder_10_8.sv
// Bench for rs_decoder_10_8: fixed vector table, start-held restart,
// mid-decode reset, and random codewords against a polynomial-evaluation model.
module tb_rs_decoder_10_8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rs_decoder_10_8_if bus();

  rs_decoder_10_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] code;
    logic [63:0] data;
    logic        det;
    logic        cor;
    logic        unc;
    logic [3:0]  pos;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Reference model: direct GF(256) arithmetic and polynomial evaluation
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (16'(a) << i);
    end
    for (int i = 15; i >= 8; i--) begin
      if (p[i]) p = p ^ (16'h011D << (i - 8));
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] gf_pow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gf_mul(a, 8'(x)) == 8'h01) r = 8'(x);
    end
    return r;
  endfunction

  function automatic vec_t model(input logic [79:0] code);
    vec_t       e;
    logic [7:0] c [10];
    logic [7:0] s0;
    logic [7:0] s1;
    int         hit;
    for (int k = 0; k < 10; k++) c[k] = code[8*k +: 8];
    s0 = 8'h00;
    s1 = 8'h00;
    for (int k = 0; k < 10; k++) begin
      s0 = s0 ^ c[k];
      s1 = s1 ^ gf_mul(c[k], gf_pow(k));
    end
    hit = -1;
    if (s0 != 8'h00 && s1 != 8'h00) begin
      for (int j = 9; j >= 0; j--) begin
        if (gf_mul(s0, gf_pow(j)) == s1) hit = j;
      end
    end
    e.code = code;
    e.det  = (s0 != 8'h00) || (s1 != 8'h00);
    e.cor  = (hit >= 0);
    e.unc  = e.det && !e.cor;
    e.pos  = (hit >= 0) ? 4'(hit) : 4'd0;
    if (hit >= 0) c[hit] = c[hit] ^ s0;
    for (int i = 0; i < 8; i++) e.data[8*i +: 8] = c[i+2];
    return e;
  endfunction

  // Builds a valid codeword around random data: solve c0, c1 so c(1)=c(alpha)=0.
  function automatic logic [79:0] encode(input logic [63:0] d);
    logic [79:0] cw;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  p1;
    a = 8'h00;
    b = 8'h00;
    for (int k = 2; k < 10; k++) begin
      a = a ^ d[8*(k-2) +: 8];
      b = b ^ gf_mul(d[8*(k-2) +: 8], gf_pow(k));
    end
    p1 = gf_mul(a ^ b, gf_inv(8'h03));
    cw = {d, p1, a ^ p1};
    return cw;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_result(input string name, input vec_t e);
    chk({name, "_data"}, 80'(bus.data_out), 80'(e.data));
    chk({name, "_flags"},
        80'({bus.err_detected, bus.err_corrected, bus.err_uncorrectable, bus.err_pos}),
        80'({e.det, e.cor, e.unc, e.pos}));
  endtask

  // Caller has start/code_in set up before the next edge (E0).
  task automatic launch_wait(input bit hold, output int lat);
    logic [95:0] r;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    r = {$urandom(), $urandom(), $urandom()};
    bus.code_in = r[79:0];
    chk("busy_after_start", 80'(bus.busy), 80'(1));
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        lat = c;
        break;
      end
    end
    chk("latency", 80'(lat), 80'(21));
    chk("busy_at_done", 80'(bus.busy), 80'(0));
  endtask

  task automatic decode_and_check(input string name, input vec_t e);
    int lat;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.code_in = e.code;
    launch_wait(1'b0, lat);
    chk_result(name, e);
    @(posedge clk);
    #1;
    chk({name, "_pulse_end"}, 80'(bus.valid_out), 80'(0));
    chk_result({name, "_hold"}, e);
  endtask

  vec_t vecs [7];

  initial begin
    int          lat;
    logic        seen;
    logic [63:0] d;
    logic [79:0] cw;
    vec_t        e;

    total = 0;
    bad   = 0;

    // code, data, det, cor, unc, pos
    vecs[0] = '{80'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{80'h0000_0000_0000_0001_0302, 64'h1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2] = '{80'h0000_0000_1000_0001_0302, 64'h1, 1'b1, 1'b1, 1'b0, 4'd5};
    vecs[3] = '{80'h0000_0000_0000_0001_0303, 64'h1, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[4] = '{80'h0000_0000_0000_0001_0203, 64'h1, 1'b1, 1'b0, 1'b1, 4'd0};
    vecs[5] = '{80'h0100_0000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 1'b0, 4'd9};
    vecs[6] = '{80'h0000_0000_0000_0001_0002, 64'h1, 1'b1, 1'b1, 1'b0, 4'd1};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.code_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 80'(bus.data_out), 80'(0));
    chk("reset_ctl",
        80'({bus.valid_out, bus.busy, bus.err_detected, bus.err_corrected,
             bus.err_uncorrectable, bus.err_pos}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed vectors
    for (int i = 0; i < 7; i++) begin
      decode_and_check($sformatf("vec%0d", i), vecs[i]);
    end

    // start held high: the edge after completion starts the next decode
    @(negedge clk);
    bus.start   = 1'b1;
    bus.code_in = vecs[2].code;
    launch_wait(1'b1, lat);
    bus.code_in = vecs[6].code;
    chk_result("hold_first", vecs[2]);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("restart_busy", 80'(bus.busy), 80'(1));
    chk("restart_no_valid", 80'(bus.valid_out), 80'(0));
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        lat = c;
        break;
      end
    end
    chk("restart_latency", 80'(lat), 80'(21));
    chk_result("hold_second", vecs[6]);

    // Reset at E8 of a decode
    decode_and_check("pre_reset", vecs[2]);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.code_in = vecs[5].code;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_data", 80'(bus.data_out), 80'(0));
    chk("abort_ctl",
        80'({bus.valid_out, bus.busy, bus.err_detected, bus.err_corrected,
             bus.err_uncorrectable, bus.err_pos}), 80'(0));
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.valid_out || bus.busy) seen = 1'b1;
    end
    chk("abort_quiet", 80'(seen), 80'(0));
    @(negedge clk);
    rst_n       = 1'b1;
    bus.start   = 1'b1;
    bus.code_in = vecs[3].code;
    launch_wait(1'b0, lat);
    chk_result("after_reset", vecs[3]);

    // Random codewords with 0..2 symbol errors against the model
    for (int n = 0; n < 30; n++) begin
      d  = {$urandom(), $urandom()};
      cw = encode(d);
      for (int m = 0; m < int'($urandom_range(0, 2)); m++) begin
        int p;
        p = int'($urandom_range(0, 9));
        cw[8*p +: 8] = cw[8*p +: 8] ^ 8'($urandom_range(1, 255));
      end
      e = model(cw);
      decode_and_check($sformatf("rand%0d", n), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_decoder_10_8.md
RS_DECODER_10_8 -- requirements
Module: rs_decoder_10_8

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to decode; sampled only in IDLE.
REQ-004 SHALL have port code_in, input, 80, codeword; symbol c_k = code_in[8k+7:8k], k=0..9.
REQ-005 SHALL have port data_out, output, 64, corrected data; data symbol i = c_(i+2), i=0..7.
REQ-006 SHALL have port valid_out, output, 1, one-cycle pulse marking a completed decode.
REQ-007 SHALL have port busy, output, 1, high while a decode is in progress.
REQ-008 SHALL have port err_detected, output, 1, nonzero syndrome.
REQ-009 SHALL have port err_corrected, output, 1, single-symbol error located and fixed.
REQ-010 SHALL have port err_uncorrectable, output, 1, error detected but not locatable.
REQ-011 SHALL have port err_pos, output, 4, corrected symbol index k (0..9); 0 when none.

Function
REQ-012 SHALL use GF(256) arithmetic with primitive polynomial 0x11D and alpha = 0x02.
REQ-013 SHALL treat the codeword as c(x) = sum of c_k x^k, with generator g(x) = (x+1)(x+alpha); parity is c_0 and c_1.
REQ-014 SHALL implement states IDLE, SYND, SEARCH, CORRECT.
REQ-015 SHALL, in IDLE on a clock edge E0 with start=1, latch code_in, clear the syndromes, assert busy and enter SYND.
REQ-016 SHALL, in SYND over edges E1..E10, process c_9 down to c_0 using S0 <- S0 ^ c_k and S1 <- S1*alpha ^ c_k, then enter SEARCH.
REQ-017 SHALL, in SEARCH over edges E11..E20, compare S0*alpha^j against S1 for j=0..9, using a running product register that starts at S0 and is multiplied by alpha each cycle, and record the first match.
REQ-018 SHALL always spend exactly 10 cycles in SEARCH, even after a match, so that decode time is constant.
REQ-019 SHALL, at edge E21 (CORRECT), update data_out and the flags, pulse valid_out, deassert busy and return to IDLE; total latency is 21 cycles from start.
REQ-020 SHALL classify S0=0 and S1=0 as no error: all flags 0, data_out equal to the latched data.
REQ-021 SHALL classify S0!=0, S1!=0 with a match at j as correctable: XOR c_j with S0, set err_detected=1, err_corrected=1, err_pos=j.
REQ-022 SHALL classify exactly one of S0, S1 as zero, or both nonzero with no match, as uncorrectable: err_detected=1, err_uncorrectable=1, err_pos=0, data_out equal to the uncorrected latched data.
REQ-023 SHALL leave data_out unchanged when the corrected position j is 0 or 1 (parity), while still setting err_corrected=1.
REQ-024 SHALL hold data_out and all flags stable from E21 until the next completion.
REQ-025 SHALL ignore start while busy; start held high after completion is sampled at E22 and begins a new decode.
REQ-026 SHALL ignore code_in changes after E0.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-decode, immediately enter IDLE and set data_out, syndromes, valid_out, busy, all err flags and err_pos to 0.
REQ-028 SHALL produce no valid_out for an aborted decode, and SHALL accept start on the first edge after rst_n deasserts.

Verification
REQ-029 SHALL cover: code_in=80'h0 -> valid_out at E21; data_out=0; all flags 0.
REQ-030 SHALL cover: code_in=80'h0000_0000_0000_0001_0302 (valid codeword) -> data_out=64'h1; err_detected=0.
REQ-031 SHALL cover: code_in=80'h0000_0000_1000_0001_0302 (error 0x10 at c_5) -> S0=0x10, S1=0x3A; err_corrected=1; err_pos=5; data_out=64'h1.
REQ-032 SHALL cover: code_in=80'h0000_0000_0000_0001_0303 (error at c_0) -> err_corrected=1; err_pos=0; data_out=64'h1.
REQ-033 SHALL cover: code_in=80'h0000_0000_0000_0001_0203 (errors at c_0 and c_1; S0=0, S1=0x03) -> err_uncorrectable=1; data_out=64'h1.
REQ-034 SHALL cover: rst_n pulsed low at E8 -> all outputs 0 and no valid_out; start at the next edge -> normal 21-cycle decode.
